// File: rtl/sound_pkg.sv
// Shared types and defaults for the sound DMA scheduler.
package sound_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DONE,
        ST_RELEASE
    } state_t;

    localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd50000;

endpackage

// File: rtl/sound_sync.sv
// N-stage flip-flop synchroniser with a configurable reset level.
module sound_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sound_dma_sched.sv
// Schedules DSP 8/16-bit DMA requests onto ISA channels 1 and 5.
//   state   | meaning
//   IDLE    | no transfer, waiting for a DSP request
//   REQ     | DRQ raised, waiting for DACK (timeout counter running)
//   XFER    | DACK low, waiting for the IOW rising edge to latch data
//   DONE    | one-cycle ack to the DSP, DRQ already low
//   RELEASE | waiting for the host to drop DACK
module sound_dma_sched
    import sound_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dsp_req8,
    input  logic        dsp_req16,
    input  logic        dma_16_en,
    output logic        dsp_ack,
    output logic [15:0] dsp_readdata,
    output logic        isa_drq1,
    output logic        isa_drq5,
    input  logic        isa_dack1_n,
    input  logic        isa_dack5_n,
    input  logic        isa_iow_n,
    input  logic        isa_tc,
    input  logic [15:0] isa_data,
    output logic        tc_pulse,
    output logic        timeout_err,
    output logic        busy
);

    logic dack1_s, dack5_s, iow_s, tc_s;

    sound_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dack1 (
        .clk(clk), .rst(rst), .d_i(isa_dack1_n), .q_o(dack1_s));
    sound_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dack5 (
        .clk(clk), .rst(rst), .d_i(isa_dack5_n), .q_o(dack5_s));
    sound_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_iow (
        .clk(clk), .rst(rst), .d_i(isa_iow_n), .q_o(iow_s));
    sound_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tc (
        .clk(clk), .rst(rst), .d_i(isa_tc), .q_o(tc_s));

    state_t      state_q;
    logic        ch16_q;
    logic        last16_q;
    logic [15:0] cnt_q;
    logic        drq1_q, drq5_q;
    logic        ack_q, tcp_q, terr_q;
    logic [15:0] rdata_q;
    logic        iow_prev_q;

    logic pend8, pend16, sel16_d, dack_sel, iow_rise;

    assign pend8    = dsp_req8;
    assign pend16   = dsp_req16 & dma_16_en;
    // Round-robin: the 16-bit channel wins only if channel 1 is idle or was served last.
    assign sel16_d  = pend16 & (~pend8 | ~last16_q);
    assign dack_sel = ch16_q ? dack5_s : dack1_s;
    assign iow_rise = iow_s & ~iow_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ch16_q     <= 1'b0;
            last16_q   <= 1'b1;
            cnt_q      <= '0;
            drq1_q     <= 1'b0;
            drq5_q     <= 1'b0;
            ack_q      <= 1'b0;
            tcp_q      <= 1'b0;
            terr_q     <= 1'b0;
            rdata_q    <= '0;
            iow_prev_q <= 1'b1;
        end else begin
            iow_prev_q <= iow_s;
            ack_q      <= 1'b0;
            tcp_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pend8 | pend16) begin
                        ch16_q   <= sel16_d;
                        last16_q <= sel16_d;
                        cnt_q    <= '0;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    drq1_q <= ~ch16_q;
                    drq5_q <= ch16_q;
                    if (!dack_sel) begin
                        state_q <= ST_XFER;
                    end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
                        drq1_q  <= 1'b0;
                        drq5_q  <= 1'b0;
                        terr_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_XFER: begin
                    // Host released DACK before the strobe: bus cycle aborted, re-request.
                    if (dack_sel) begin
                        cnt_q   <= '0;
                        state_q <= ST_REQ;
                    end else if (iow_rise) begin
                        rdata_q <= ch16_q ? isa_data : {8'h00, isa_data[7:0]};
                        ack_q   <= 1'b1;
                        tcp_q   <= tc_s;
                        drq1_q  <= 1'b0;
                        drq5_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (dack_sel) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dsp_ack      = ack_q;
    assign dsp_readdata = rdata_q;
    assign isa_drq1     = drq1_q;
    assign isa_drq5     = drq5_q;
    assign tc_pulse     = tcp_q;
    assign timeout_err  = terr_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sound_dma_sched.sv
// Directed bench for sound_dma_sched: transfers, arbitration, timeout, abort, reset.
module tb_sound_dma_sched;

    logic        clk;
    logic        rst;
    logic        dsp_req8, dsp_req16, dma_16_en;
    logic        dsp_ack;
    logic [15:0] dsp_readdata;
    logic        isa_drq1, isa_drq5;
    logic        isa_dack1_n, isa_dack5_n, isa_iow_n, isa_tc;
    logic [15:0] isa_data;
    logic        tc_pulse, timeout_err, busy;

    int errors = 0;
    int checks = 0;
    int ack_total = 0;
    int drq5_cyc = 0;

    sound_dma_sched #(.SYNC_STAGES(2), .TIMEOUT_CYC(16'd100)) dut (
        .clk(clk), .rst(rst),
        .dsp_req8(dsp_req8), .dsp_req16(dsp_req16), .dma_16_en(dma_16_en),
        .dsp_ack(dsp_ack), .dsp_readdata(dsp_readdata),
        .isa_drq1(isa_drq1), .isa_drq5(isa_drq5),
        .isa_dack1_n(isa_dack1_n), .isa_dack5_n(isa_dack5_n),
        .isa_iow_n(isa_iow_n), .isa_tc(isa_tc), .isa_data(isa_data),
        .tc_pulse(tc_pulse), .timeout_err(timeout_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dsp_ack)  ack_total++;
        if (isa_drq5) drq5_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One host-side DMA cycle on whichever channel raised DRQ.
    task automatic run_xfer(input logic [15:0] data, input logic tc, input bit drop,
                            output logic got16, output logic [15:0] rd,
                            output logic tcp, output logic drq_ack);
        bit seen;
        seen = 0; rd = '0; tcp = 1'b0; drq_ack = 1'b1;
        for (int n = 0; n < 30 && !(isa_drq1 || isa_drq5); n++) @(negedge clk);
        check("drq_raised", {31'd0, isa_drq1 | isa_drq5}, 32'd1);
        got16 = isa_drq5;
        repeat (4) @(negedge clk);
        if (got16) isa_dack5_n = 1'b0; else isa_dack1_n = 1'b0;
        if (drop) begin dsp_req8 = 1'b0; dsp_req16 = 1'b0; end
        repeat (5) @(negedge clk);
        isa_data = data; isa_tc = tc; isa_iow_n = 1'b0;
        repeat (3) @(negedge clk);
        isa_iow_n = 1'b1;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (dsp_ack) begin
                seen = 1; rd = dsp_readdata; tcp = tc_pulse; drq_ack = isa_drq1 | isa_drq5;
            end
        end
        check("ack_seen", {31'd0, seen}, 32'd1);
        isa_dack1_n = 1'b1; isa_dack5_n = 1'b1; isa_tc = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic        g16, tcp, dak;
        logic [15:0] rd;
        int          a0, d0, hi;
        logic [3:0]  order;

        rst = 1'b1; dsp_req8 = 1'b0; dsp_req16 = 1'b0; dma_16_en = 1'b0;
        isa_dack1_n = 1'b1; isa_dack5_n = 1'b1; isa_iow_n = 1'b1; isa_tc = 1'b0;
        isa_data = '0;
        repeat (3) @(negedge clk);
        check("rst_drq1", {31'd0, isa_drq1}, 32'd0);
        check("rst_drq5", {31'd0, isa_drq5}, 32'd0);
        check("rst_ack", {31'd0, dsp_ack}, 32'd0);
        check("rst_tc", {31'd0, tc_pulse}, 32'd0);
        check("rst_data", {16'd0, dsp_readdata}, 32'd0);
        check("rst_terr", {31'd0, timeout_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 8-bit transfer, request dropped mid-transfer
        dsp_req8 = 1'b1;
        @(negedge clk);
        check("req_entry_busy", {31'd0, busy}, 32'd1);
        check("req_entry_drq_low", {31'd0, isa_drq1}, 32'd0);
        @(negedge clk);
        check("drq1_rise", {31'd0, isa_drq1}, 32'd1);
        a0 = ack_total;
        run_xfer(16'hA55A, 1'b0, 1'b1, g16, rd, tcp, dak);
        check("x8_chan", {31'd0, g16}, 32'd0);
        check("x8_data", {16'd0, rd}, 32'h005A);
        check("x8_tc", {31'd0, tcp}, 32'd0);
        check("x8_drq_at_ack", {31'd0, dak}, 32'd0);
        check("x8_ack_once", ack_total - a0, 32'd1);
        repeat (6) @(negedge clk);
        check("x8_idle", {31'd0, busy}, 32'd0);

        // 16-bit transfer with TC
        dma_16_en = 1'b1; dsp_req16 = 1'b1;
        a0 = ack_total;
        run_xfer(16'h1234, 1'b1, 1'b1, g16, rd, tcp, dak);
        check("x16_chan", {31'd0, g16}, 32'd1);
        check("x16_data", {16'd0, rd}, 32'h1234);
        check("x16_tc", {31'd0, tcp}, 32'd1);
        check("x16_drq_at_ack", {31'd0, dak}, 32'd0);
        check("x16_ack_once", ack_total - a0, 32'd1);
        repeat (6) @(negedge clk);

        // arbitration, both held: last served was channel 5
        dsp_req8 = 1'b1; dsp_req16 = 1'b1;
        order = '0;
        for (int k = 0; k < 4; k++) begin
            run_xfer(16'h0101 * (k + 1), 1'b0, 1'b0, g16, rd, tcp, dak);
            order[k] = g16;
        end
        dsp_req8 = 1'b0; dsp_req16 = 1'b0;
        check("arb_order_1515", {28'd0, order}, 32'b1010);
        repeat (6) @(negedge clk);

        dma_16_en = 1'b0; dsp_req8 = 1'b1; dsp_req16 = 1'b1;
        d0 = drq5_cyc; order = '1;
        for (int k = 0; k < 4; k++) begin
            run_xfer(16'h0202 * (k + 1), 1'b0, 1'b0, g16, rd, tcp, dak);
            order[k] = g16;
        end
        dsp_req8 = 1'b0; dsp_req16 = 1'b0;
        check("arb_order_1111", {28'd0, order}, 32'b0000);
        check("arb_drq5_never", drq5_cyc - d0, 32'd0);
        repeat (6) @(negedge clk);

        // timeout with no DACK
        a0 = ack_total;
        dsp_req8 = 1'b1;
        for (int n = 0; n < 10 && !isa_drq1; n++) @(negedge clk);
        hi = 0;
        while (isa_drq1 && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        dsp_req8 = 1'b0;
        check("to_drq_high_cycles", hi, 32'd99);
        check("to_terr", {31'd0, timeout_err}, 32'd1);
        repeat (4) @(negedge clk);
        check("to_no_ack", ack_total - a0, 32'd0);
        check("to_idle", {31'd0, busy}, 32'd0);
        dsp_req8 = 1'b1;
        run_xfer(16'h7E81, 1'b0, 1'b1, g16, rd, tcp, dak);
        check("to_next_data", {16'd0, rd}, 32'h0081);
        check("to_terr_sticky", {31'd0, timeout_err}, 32'd1);
        repeat (6) @(negedge clk);

        // abort: DACK rises in XFER before IOW
        dma_16_en = 1'b1; dsp_req16 = 1'b1;
        for (int n = 0; n < 10 && !isa_drq5; n++) @(negedge clk);
        a0 = ack_total;
        isa_dack5_n = 1'b0;
        repeat (5) @(negedge clk);
        isa_dack5_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_drq_kept", {31'd0, isa_drq5}, 32'd1);
        check("abort_no_ack", ack_total - a0, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd1);
        run_xfer(16'hBEEF, 1'b0, 1'b1, g16, rd, tcp, dak);
        check("abort_retry_chan", {31'd0, g16}, 32'd1);
        check("abort_retry_data", {16'd0, rd}, 32'hBEEF);
        repeat (6) @(negedge clk);

        // reset asserted in XFER
        dsp_req8 = 1'b1;
        for (int n = 0; n < 10 && !isa_drq1; n++) @(negedge clk);
        isa_dack1_n = 1'b0;
        repeat (5) @(negedge clk);
        check("prerst_drq1", {31'd0, isa_drq1}, 32'd1);
        a0 = ack_total;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_drq1", {31'd0, isa_drq1}, 32'd0);
        check("midrst_ack", {31'd0, dsp_ack}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_terr", {31'd0, timeout_err}, 32'd0);
        check("midrst_data", {16'd0, dsp_readdata}, 32'd0);
        check("midrst_tc", {31'd0, tc_pulse}, 32'd0);
        rst = 1'b0; dsp_req8 = 1'b0; isa_dack1_n = 1'b1;
        repeat (4) @(negedge clk);
        check("postrst_no_ack", ack_total - a0, 32'd0);
        check("postrst_idle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
